cmd_data_tx: RTL

Transmit-side packet framer, the counterpart of the command/data splitter on the receive path. Emits either a 2-word command packet from a 64-bit command register, or a data packet streamed out of the 512x32 packet RAM. Drives a 32-bit word stream plus per-packet data_length/total_length. The receive side classifies any packet with data_length==16 or total_length==36 as a command.

---
 rtl/cmd_data_tx_pkg.sv | 25 ++
 rtl/cmd_data_tx_skid_buf.sv | 67 ++++++
 rtl/cmd_data_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cmd_data_tx_pkg.sv
// Shared constants and state encoding for the command/data transmit framer.
// The receive-side splitter imports the same command-length constants.
package cmd_data_tx_pkg;

    localparam int HDR_BYTES    = 8;
    localparam int IP_HDR_BYTES = 20;
    localparam int MIN_WORDS    = 3;
    localparam int GAP_CYCLES   = 4;

    localparam logic [15:0] CMD_DATA_LEN  = 16'd16;
    localparam logic [15:0] CMD_TOTAL_LEN = 16'd36;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DRAIN,
        S_GAP
    } state_t;

    function automatic logic [15:0] data_len(input logic [15:0] words);
        return (words << 2) + 16'(HDR_BYTES);
    endfunction

endpackage

// File: rtl/cmd_data_tx_skid_buf.sv
// Two-entry valid/ready buffer carrying a last flag; entry 0 is the output head.
// The producer guarantees it never pushes into a full buffer without a pop.
module tx_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        push_last_i,
    input  logic        pop_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        last_o,
    output logic [1:0]  count_o
);

    logic [31:0] e0_q, e1_q;
    logic        l0_q, l1_q;
    logic [1:0]  cnt_q;
    logic        pop;

    assign pop     = pop_i && (cnt_q != 2'd0);
    assign valid_o = cnt_q != 2'd0;
    assign data_o  = e0_q;
    assign last_o  = l0_q;
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            l0_q  <= 1'b0;
            l1_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_q <= push_data_i;
                        l0_q <= push_last_i;
                    end else begin
                        e1_q <= push_data_i;
                        l1_q <= push_last_i;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    l0_q  <= l1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_q <= push_data_i;
                        l0_q <= push_last_i;
                    end else begin
                        e0_q <= e1_q;
                        l0_q <= l1_q;
                        e1_q <= push_data_i;
                        l1_q <= push_last_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cmd_data_tx.sv
// Transmit framer: 2-word command packets or RAM-streamed data packets.
// Optional TX_PKT_GAP_EN inserts a fixed idle gap after every packet.
module cmd_data_tx
    import cmd_data_tx_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_req,
    input  logic [63:0]       cmd,
    input  logic              data_req,
    input  logic [ADDR_W:0]   data_words,
    output logic              req_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              ram_rd_en,
    input  logic [31:0]       ram_rd_data,
    output logic [31:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [15:0]       tx_data_length,
    output logic [15:0]       tx_total_length,
    output logic              tx_last
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] MIN_W = CW'(MIN_WORDS);
    localparam logic [CW-1:0] MAX_W = CW'(1 << ADDR_W);
`ifdef TX_PKT_GAP_EN
    localparam state_t DONE_ST = S_GAP;
`else
    localparam state_t DONE_ST = S_IDLE;
`endif

    state_t      state_q;
    logic [CW-1:0] rd_ptr_q, words_q;
    logic        inflight_q, inflight_last_q, lo_pend_q, req_err_q;
    logic [31:0] cmd_lo_q;
    logic [15:0] dlen_q, tlen_q;
    logic [1:0]  gap_q, cnt;

    logic        valid_words, pop, has_room, acc_cmd, acc_data;
    logic        data_rd, last_rd, push, push_last;
    logic [31:0] push_data;
    logic [2:0]  occ;

    // Credit counts the word leaving this cycle so the stream runs at 1 word/cycle.
    always_comb begin
        valid_words = (data_words >= MIN_W) && (data_words <= MAX_W);
        pop         = tx_valid && tx_ready;
        occ         = {1'b0, cnt} + {2'b0, inflight_q} - {2'b0, pop};
        has_room    = occ < 3'd2;
        acc_cmd     = (state_q == S_IDLE) && cmd_req;
        acc_data    = (state_q == S_IDLE) && data_req && !cmd_req && valid_words;
        data_rd     = (state_q == S_DATA) && has_room;
        last_rd     = rd_ptr_q == (words_q - 1'b1);
        ram_rd_en   = acc_data || data_rd;
        ram_rd_addr = data_rd ? rd_ptr_q[ADDR_W-1:0] : '0;
    end

    always_comb begin
        push      = 1'b0;
        push_data = ram_rd_data;
        push_last = inflight_last_q;
        unique case (1'b1)
            acc_cmd: begin
                push      = 1'b1;
                push_data = cmd[63:32];
                push_last = 1'b0;
            end
            lo_pend_q: begin
                push      = 1'b1;
                push_data = cmd_lo_q;
                push_last = 1'b1;
            end
            inflight_q: push = 1'b1;
            default: ;
        endcase
    end

    tx_skid_buf u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .push_last_i (push_last),
        .pop_i       (tx_ready),
        .valid_o     (tx_valid),
        .data_o      (tx_data),
        .last_o      (tx_last),
        .count_o     (cnt)
    );

    assign req_err         = req_err_q;
    assign busy            = state_q != S_IDLE;
    assign tx_data_length  = dlen_q;
    assign tx_total_length = tlen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            rd_ptr_q        <= '0;
            words_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            lo_pend_q       <= 1'b0;
            req_err_q       <= 1'b0;
            cmd_lo_q        <= '0;
            dlen_q          <= '0;
            tlen_q          <= '0;
            gap_q           <= '0;
        end else begin
            req_err_q       <= (state_q == S_IDLE) && data_req && !cmd_req
                               && !valid_words;
            inflight_q      <= ram_rd_en;
            inflight_last_q <= data_rd && last_rd;
            unique case (state_q)
                S_IDLE: begin
                    if (acc_cmd) begin
                        cmd_lo_q  <= cmd[31:0];
                        lo_pend_q <= 1'b1;
                        dlen_q    <= CMD_DATA_LEN;
                        tlen_q    <= CMD_TOTAL_LEN;
                        state_q   <= S_CMD;
                    end else if (acc_data) begin
                        words_q  <= data_words;
                        rd_ptr_q <= CW'(1);
                        dlen_q   <= data_len(16'(data_words));
                        tlen_q   <= data_len(16'(data_words)) + 16'(IP_HDR_BYTES);
                        state_q  <= S_DATA;
                    end
                end
                S_CMD: begin
                    lo_pend_q <= 1'b0;
                    if (pop && tx_last) state_q <= DONE_ST;
                end
                S_DATA: begin
                    if (data_rd) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        if (last_rd) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && tx_last) state_q <= DONE_ST;
                end
                S_GAP: begin
                    if (gap_q == 2'(GAP_CYCLES - 1)) begin
                        gap_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
